// File: rtl/vram_arbiter_pkg.sv
// Shared constants for the video RAM arbiter and its clear engine.
package vram_arbiter_pkg;

  localparam int AW = 16;
  localparam int DW = 12;
  localparam logic [15:0] CLR_LAST = 16'hFFFF;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [11:0] COL_BLACK = 12'h000;

endpackage

// File: rtl/vram_clear_engine.sv
// Full-screen clear engine: sweeps addresses 0..CLR_LAST writing one fill colour,
// advancing only in cycles where the arbiter grants it the RAM.
module vram_clear_engine #(
  parameter int AW = vram_arbiter_pkg::AW,
  parameter int DW = vram_arbiter_pkg::DW,
  parameter logic [AW-1:0] CLR_LAST = AW'(vram_arbiter_pkg::CLR_LAST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] color,
  input  logic          grant,
  output logic          busy,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          we
);

  import vram_arbiter_pkg::*;

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic [DW-1:0] col;

  // Two-state sweep: a start in IDLE latches the colour; further starts while clearing are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      col   <= DW'(COL_BLACK);
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            col   <= color;
            cnt   <= '0;
            state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (grant) begin
            if (cnt == CLR_LAST) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_CLEAR);
  assign addr = cnt;
  assign data = col;
  assign we   = busy & grant;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display reads > clear engine > pixel writes,
// one RAM access per cycle.
module vram_arbiter #(
  parameter int AW = vram_arbiter_pkg::AW,
  parameter int DW = vram_arbiter_pkg::DW,
  parameter logic [AW-1:0] CLR_LAST = AW'(vram_arbiter_pkg::CLR_LAST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  import vram_arbiter_pkg::*;

  logic [AW-1:0] clr_addr;
  logic [DW-1:0] clr_data;
  logic          clr_we;

  vram_clear_engine #(
    .AW       (AW),
    .DW       (DW),
    .CLR_LAST (CLR_LAST)
  ) u_clear (
    .clk   (clk),
    .rst   (rst),
    .start (clr_start),
    .color (clr_color),
    .grant (!disp_req),
    .busy  (clr_busy),
    .addr  (clr_addr),
    .data  (clr_data),
    .we    (clr_we)
  );

  // A pending clear start already owns the next cycles, so a write must not slip in beside it.
  assign wr_ready = !rst && !disp_req && !clr_busy && !clr_start;

  // RAM port mux in fixed priority order; the idle default parks on the write address.
  always_comb begin
    mem_addr  = wr_addr;
    mem_we    = 1'b0;
    mem_wdata = wr_data;
    if (disp_req) begin
      mem_addr = disp_addr;
    end else if (clr_we) begin
      mem_addr  = clr_addr;
      mem_we    = 1'b1;
      mem_wdata = clr_data;
    end else if (wr_valid && wr_ready) begin
      mem_we = 1'b1;
    end
  end

  // The RAM read is synchronous, so read data lines up with the request delayed one cycle.
  always_ff @(posedge clk) begin
    if (rst) disp_valid <= 1'b0;
    else     disp_valid <= disp_req;
  end

  assign disp_data = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural RAM and a display-read scoreboard.
module tb_vram_arbiter;

  localparam logic [15:0] CL = 16'h13FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic [11:0] disp_data;
  logic        disp_valid;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic        clr_start;
  logic [11:0] clr_color;
  logic        clr_busy;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  logic        bd_we;
  logic [15:0] bd_addr;
  logic [11:0] bd_data;

  logic [11:0] ram     [0:65535];
  logic [11:0] exp_mem [0:65535];
  logic [11:0] sbq [$];

  int compared = 0;
  int failed   = 0;

  vram_arbiter #(.CLR_LAST(CL)) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .clr_start  (clr_start),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM with a bench backdoor for preloading.
  always @(posedge clk) begin
    if (bd_we)       ram[bd_addr]  <= bd_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic dreq, input logic [15:0] daddr, input logic wv,
                               input logic [15:0] wa, input logic [11:0] wd,
                               input logic cs, input logic [11:0] cc);
    disp_req  = dreq;
    disp_addr = daddr;
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    clr_start = cs;
    clr_color = cc;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [11:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    exp_mem[a] = d;
    nextCycle();
    bd_we = 1'b0;
  endtask

  task automatic checkFill(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                           input logic [11:0] col);
    int first_bad;
    first_bad = -1;
    for (int a = int'(lo); a <= int'(hi); a++) begin
      if (first_bad < 0 && ram[a] !== col) first_bad = a;
      exp_mem[a] = col;
    end
    checkOutput(tag, first_bad, -1);
  endtask

  // Display-read scoreboard and display-priority checks on every non-reset cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (disp_valid) begin
        checkOutput("sb_depth", (sbq.size() > 0), 1);
        if (sbq.size() > 0) checkOutput("disp_data_sb", disp_data, sbq.pop_front());
      end
      if (disp_req) begin
        checkOutput("disp_no_we", mem_we, 0);
        checkOutput("disp_addr_mux", mem_addr, disp_addr);
        sbq.push_back(exp_mem[disp_addr]);
      end
    end
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b, nd, seq_bad, rdy_bad, last_wr;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    rst = 1'b1;
    applyStimulus(0, 16'h0000, 1, 16'h0055, 12'h123, 0, 12'h000);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_wr_ready", wr_ready, 0);
    checkOutput("rst_clr_busy", clr_busy, 0);
    checkOutput("rst_disp_valid", disp_valid, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_idle_addr", mem_addr, 16'h0055);
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 16'h0000, 0, 16'h0000, 12'h000, 0, 12'h000);
    @(negedge clk);
    checkOutput("idle_wr_ready", wr_ready, 1);
    nextCycle();

    preload(16'h0102, 12'hABC);
    for (int i = 0; i < 64; i++) preload(16'h8000 + 16'(i), 12'(12'h3C3 ^ (i * 37)));

    // Display read only
    applyStimulus(1, 16'h0102, 0, 16'h0000, 12'h000, 0, 12'h000);
    nextCycle();
    disp_req = 1'b0;
    @(negedge clk);
    checkOutput("rd_valid", disp_valid, 1);
    checkOutput("rd_data", disp_data, 12'hABC);
    nextCycle();
    @(negedge clk);
    checkOutput("rd_valid_drop", disp_valid, 0);

    // Pixel write held off by the display window
    applyStimulus(1, 16'h0102, 1, 16'h0010, 12'hF00, 0, 12'h000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("wr_blocked", wr_ready, 0);
      nextCycle();
    end
    disp_req = 1'b0;
    @(negedge clk);
    checkOutput("wr_accept_rdy", wr_ready, 1);
    checkOutput("wr_accept_we", mem_we, 1);
    checkOutput("wr_accept_addr", mem_addr, 16'h0010);
    checkOutput("wr_accept_data", mem_wdata, 12'hF00);
    nextCycle();
    wr_valid = 1'b0;
    exp_mem[16'h0010] = 12'hF00;
    applyStimulus(1, 16'h0010, 0, 16'h0000, 12'h000, 0, 12'h000);
    nextCycle();
    disp_req = 1'b0;
    @(negedge clk);
    checkOutput("wr_readback", disp_data, 12'hF00);
    nextCycle();

    // Full clear without display traffic
    applyStimulus(0, 16'h0000, 0, 16'h0000, 12'h000, 1, 12'h0F0);
    @(negedge clk);
    checkOutput("clr_start_rdy", wr_ready, 0);
    checkOutput("clr_start_busy", clr_busy, 0);
    nextCycle();
    clr_start = 1'b0;
    b = 0; last_wr = -1;
    for (int c = 0; c < int'(CL) + 20; c++) begin
      @(negedge clk);
      if (!clr_busy) break;
      b++;
      if (mem_we) last_wr = int'(mem_addr);
      nextCycle();
    end
    checkOutput("clr_len", b, int'(CL) + 1);
    checkOutput("clr_last_addr", last_wr, int'(CL));
    checkOutput("clr_end_rdy", wr_ready, 1);
    nextCycle();
    checkFill("clr_fill", 16'h0000, CL, 12'h0F0);
    applyStimulus(1, 16'h0102, 0, 16'h0000, 12'h000, 0, 12'h000);
    nextCycle();
    disp_req = 1'b0;
    nextCycle();

    // Clear interleaved with an 80% display window
    applyStimulus(0, 16'h0000, 0, 16'h0000, 12'h000, 1, 12'h00F);
    nextCycle();
    clr_start = 1'b0;
    nd = 0; seq_bad = 0;
    for (int c = 0; c < 6 * (int'(CL) + 1) + 100; c++) begin
      disp_req  = ((c % 80) < 64);
      disp_addr = 16'h8000 + 16'(c % 64);
      @(negedge clk);
      if (!clr_busy) break;
      if (!disp_req) begin
        if (mem_we !== 1'b1 || mem_addr !== 16'(nd) || mem_wdata !== 12'h00F) seq_bad++;
        nd++;
      end
      nextCycle();
    end
    checkOutput("ilv_nondisp_len", nd, int'(CL) + 1);
    checkOutput("ilv_seq", seq_bad, 0);
    disp_req = 1'b0;
    nextCycle();
    nextCycle();
    checkFill("ilv_fill", 16'h0000, CL, 12'h00F);

    // Clear and write contend; a second start mid-clear is ignored
    applyStimulus(0, 16'h0000, 1, 16'h0020, 12'hABC, 1, 12'h333);
    @(negedge clk);
    checkOutput("cont_rdy", wr_ready, 0);
    checkOutput("cont_we", mem_we, 0);
    nextCycle();
    clr_start = 1'b0;
    b = 0; seq_bad = 0; rdy_bad = 0;
    for (int c = 0; c < int'(CL) + 20; c++) begin
      @(negedge clk);
      if (!clr_busy) break;
      if (mem_addr !== 16'(b) || mem_wdata !== 12'h333) seq_bad++;
      if (wr_ready !== 1'b0) rdy_bad++;
      b++;
      nextCycle();
      clr_start = (b == 100);
      clr_color = (b == 100) ? 12'h777 : 12'h333;
    end
    checkOutput("cont_len", b, int'(CL) + 1);
    checkOutput("cont_seq", seq_bad, 0);
    checkOutput("cont_held", rdy_bad, 0);
    checkOutput("cont_wr_rdy", wr_ready, 1);
    checkOutput("cont_wr_we", mem_we, 1);
    checkOutput("cont_wr_addr", mem_addr, 16'h0020);
    checkOutput("cont_wr_data", mem_wdata, 12'hABC);
    nextCycle();
    wr_valid = 1'b0;
    nextCycle();
    checkOutput("cont_ram_wr", ram[16'h0020], 12'hABC);
    checkOutput("cont_ram_next", ram[16'h0021], 12'h333);
    checkOutput("cont_ram_last", ram[CL], 12'h333);
    exp_mem[16'h0020] = 12'hABC;

    // Reset in the middle of a clear
    preload(16'h1235, 12'h5A5);
    applyStimulus(0, 16'h0000, 0, 16'h0000, 12'h000, 1, 12'h0C0);
    nextCycle();
    clr_start = 1'b0;
    repeat (16'h1234) nextCycle();
    @(negedge clk);
    checkOutput("mid_addr", mem_addr, 16'h1234);
    checkOutput("mid_busy", clr_busy, 1);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_busy", clr_busy, 0);
    checkOutput("mid_rst_rdy", wr_ready, 1);
    checkOutput("mid_rst_we", mem_we, 0);
    nextCycle();
    checkOutput("mid_ram_kept", ram[16'h1235], 12'h5A5);
    checkOutput("mid_ram_done", ram[16'h1233], 12'h0C0);

    nextCycle();
    nextCycle();
    checkOutput("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
